// File: rtl/trap_sequencer.sv
// Machine-mode trap/return sequencer: picks exception > mret > interrupt, drains the pipeline,
// strobes one CSR commit and then holds a fetch redirect. Optional feature macro: TRAP_SEQUENCER_VECTORED_EN.
module trap_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_valid,
  input  logic [5:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_valid,
  input  logic            commit_ready,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [XLEN-1:0] csr_mip,
  input  logic [XLEN-1:0] csr_mie,
  input  logic            csr_mstatus_mie,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  output logic            flush_req,
  input  logic            flush_ack,
  output logic            trap_commit_valid,
  output logic            trap_commit_mret,
  output logic            trap_commit_intr,
  output logic [5:0]      trap_commit_code,
  output logic [XLEN-1:0] trap_commit_epc,
  output logic [XLEN-1:0] trap_commit_tval,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            busy
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DRAIN    = 2'd1;
  localparam logic [1:0] ST_COMMIT   = 2'd2;
  localparam logic [1:0] ST_REDIRECT = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            mret_q, mret_d;
  logic            intr_q, intr_d;
  logic [5:0]      code_q, code_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] target_q, target_d;

  logic [XLEN-1:0] irq_pend;
  logic            irq_take;
  logic [5:0]      irq_code;
  logic [XLEN-1:0] mtvec_base;
  logic [XLEN-1:0] irq_target;
  logic            is_idle;

  assign is_idle    = (state_q == ST_IDLE);
  assign irq_pend   = csr_mip & csr_mie;
  // Only the three machine-level sources are serviced; everything else in mip is ignored.
  assign irq_take   = csr_mstatus_mie & commit_ready & (irq_pend[11] | irq_pend[3] | irq_pend[7]);
  assign mtvec_base = {csr_mtvec[XLEN-1:2], 2'b00};

  always_comb begin
    irq_code = 6'd7;
    if (irq_pend[11]) begin
      irq_code = 6'd11;
    end else if (irq_pend[3]) begin
      irq_code = 6'd3;
    end
  end

`ifdef TRAP_SEQUENCER_VECTORED_EN
  // Vectored mode (mtvec[1:0]==01): interrupts land at base + 4*cause, wrapping at XLEN.
  assign irq_target = (csr_mtvec[1:0] == 2'b01) ? (mtvec_base + XLEN'({irq_code, 2'b00}))
                                                : mtvec_base;
  logic unused_bits;
  assign unused_bits = ^irq_pend;
`else
  assign irq_target = mtvec_base;
  logic unused_bits;
  assign unused_bits = ^{irq_pend, csr_mtvec[1:0]};
`endif

  always_comb begin
    state_d  = state_q;
    mret_d   = mret_q;
    intr_d   = intr_q;
    code_d   = code_q;
    epc_d    = epc_q;
    tval_d   = tval_q;
    target_d = target_q;
    unique case (state_q)
      ST_IDLE: begin
        if (exc_valid) begin
          state_d  = ST_DRAIN;
          mret_d   = 1'b0;
          intr_d   = 1'b0;
          code_d   = exc_code;
          epc_d    = exc_pc;
          tval_d   = exc_tval;
          target_d = mtvec_base;
        end else if (mret_valid) begin
          state_d  = ST_DRAIN;
          mret_d   = 1'b1;
          intr_d   = 1'b0;
          code_d   = '0;
          epc_d    = '0;
          tval_d   = '0;
          target_d = csr_mepc;
        end else if (irq_take) begin
          state_d  = ST_DRAIN;
          mret_d   = 1'b0;
          intr_d   = 1'b1;
          code_d   = irq_code;
          epc_d    = commit_pc;
          tval_d   = '0;
          target_d = irq_target;
        end
      end
      ST_DRAIN: begin
        if (flush_ack) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mret_q   <= 1'b0;
      intr_q   <= 1'b0;
      code_q   <= '0;
      epc_q    <= '0;
      tval_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      mret_q   <= mret_d;
      intr_q   <= intr_d;
      code_q   <= code_d;
      epc_q    <= epc_d;
      tval_q   <= tval_d;
      target_q <= target_d;
    end
  end

  // Moore outputs; data is gated so nothing leaks outside its strobe.
  assign busy              = ~is_idle;
  assign flush_req         = (state_q == ST_DRAIN);
  assign trap_commit_valid = (state_q == ST_COMMIT);
  assign trap_commit_mret  = trap_commit_valid & mret_q;
  assign trap_commit_intr  = trap_commit_valid & intr_q;
  assign trap_commit_code  = trap_commit_valid ? code_q : '0;
  assign trap_commit_epc   = trap_commit_valid ? epc_q  : '0;
  assign trap_commit_tval  = trap_commit_valid ? tval_q : '0;
  assign redirect_valid    = (state_q == ST_REDIRECT);
  assign redirect_pc       = redirect_valid ? target_q : '0;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer with a commit/redirect scoreboard.
module tb_trap_sequencer;
  localparam int XLEN = 64;

`ifdef TRAP_SEQUENCER_VECTORED_EN
  localparam logic [63:0] EXP_MEI = 64'h8000_102C;
  localparam logic [63:0] EXP_MSI = 64'h8000_100C;
`else
  localparam logic [63:0] EXP_MEI = 64'h8000_1000;
  localparam logic [63:0] EXP_MSI = 64'h8000_1000;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            exc_valid;
  logic [5:0]      exc_code;
  logic [XLEN-1:0] exc_pc;
  logic [XLEN-1:0] exc_tval;
  logic            mret_valid;
  logic            commit_ready;
  logic [XLEN-1:0] commit_pc;
  logic [XLEN-1:0] csr_mip;
  logic [XLEN-1:0] csr_mie;
  logic            csr_mstatus_mie;
  logic [XLEN-1:0] csr_mtvec;
  logic [XLEN-1:0] csr_mepc;
  logic            flush_req;
  logic            flush_ack;
  logic            trap_commit_valid;
  logic            trap_commit_mret;
  logic            trap_commit_intr;
  logic [5:0]      trap_commit_code;
  logic [XLEN-1:0] trap_commit_epc;
  logic [XLEN-1:0] trap_commit_tval;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;
  logic            busy;

  trap_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_valid(mret_valid), .commit_ready(commit_ready), .commit_pc(commit_pc),
    .csr_mip(csr_mip), .csr_mie(csr_mie), .csr_mstatus_mie(csr_mstatus_mie),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .flush_req(flush_req), .flush_ack(flush_ack),
    .trap_commit_valid(trap_commit_valid), .trap_commit_mret(trap_commit_mret),
    .trap_commit_intr(trap_commit_intr), .trap_commit_code(trap_commit_code),
    .trap_commit_epc(trap_commit_epc), .trap_commit_tval(trap_commit_tval),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mret;
    logic        intr;
    logic [5:0]  code;
    logic [63:0] epc;
    logic [63:0] tval;
  } commit_t;

  commit_t     cq[$];
  logic [63:0] rq[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a commit or a redirect.
  always @(negedge clk) begin
    commit_t e;
    if (!rst) begin
      if (trap_commit_valid) begin
        if (cq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit actual=1 required=0");
        end else begin
          e = cq.pop_front();
          check("commit_mret", 64'(trap_commit_mret), 64'(e.mret));
          check("commit_intr", 64'(trap_commit_intr), 64'(e.intr));
          check("commit_code", 64'(trap_commit_code), 64'(e.code));
          check("commit_epc",  trap_commit_epc, e.epc);
          check("commit_tval", trap_commit_tval, e.tval);
        end
      end else begin
        check("commit_idle_zero",
              64'(trap_commit_mret | trap_commit_intr | (|trap_commit_code) |
                  (|trap_commit_epc) | (|trap_commit_tval)), 64'd0);
      end
      if (redirect_valid) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_redirect actual=%h required=none", redirect_pc);
        end else begin
          check("redirect_pc", redirect_pc, rq[0]);
          if (redirect_ready) begin
            void'(rq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch_checks;
    check("busy_start", 64'(busy), 64'd1);
    check("flush_req_start", 64'(flush_req), 64'd1);
  endtask

  task automatic issue_exc(input logic [5:0] code, input logic [63:0] pc, input logic [63:0] tval,
                           input logic [63:0] mtvec, input logic [63:0] rpc);
    cq.push_back({1'b0, 1'b0, code, pc, tval});
    rq.push_back(rpc);
    check("busy_before_event", 64'(busy), 64'd0);
    csr_mtvec = mtvec;
    exc_valid = 1'b1;
    exc_code  = code;
    exc_pc    = pc;
    exc_tval  = tval;
    tick();
    exc_valid = 1'b0;
    launch_checks();
  endtask

  task automatic issue_irq(input logic [63:0] pend, input logic [63:0] cpc, input logic [63:0] mtvec,
                           input logic [5:0] code, input logic [63:0] rpc);
    cq.push_back({1'b0, 1'b1, code, cpc, 64'd0});
    rq.push_back(rpc);
    csr_mtvec       = mtvec;
    csr_mip         = pend;
    csr_mie         = pend;
    csr_mstatus_mie = 1'b1;
    commit_ready    = 1'b1;
    commit_pc       = cpc;
    tick();
    csr_mip         = '0;
    csr_mie         = '0;
    csr_mstatus_mie = 1'b0;
    commit_ready    = 1'b0;
    launch_checks();
  endtask

  task automatic ack_phase(input int dly, input bit pulse_exc);
    for (int i = 0; i < dly; i++) begin
      check("flush_req_hold", 64'(flush_req), 64'd1);
      check("busy_hold", 64'(busy), 64'd1);
      exc_valid = pulse_exc && (i == 1);
      tick();
    end
    exc_valid = 1'b0;
    flush_ack = 1'b1;
    tick();
    flush_ack = 1'b0;
    check("commit_strobe", 64'(trap_commit_valid), 64'd1);
    tick();
    check("commit_one_cycle", 64'(trap_commit_valid), 64'd0);
    check("redirect_valid_start", 64'(redirect_valid), 64'd1);
  endtask

  task automatic redir_phase(input int dly);
    for (int i = 0; i < dly; i++) begin
      check("redirect_hold", 64'(redirect_valid), 64'd1);
      tick();
    end
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    check("idle_after_redirect", 64'(busy), 64'd0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_flush_req", 64'(flush_req), 64'd0);
    check("rst_commit_valid", 64'(trap_commit_valid), 64'd0);
    check("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    check("rst_redirect_pc", redirect_pc, 64'd0);
    cq.delete();
    rq.delete();
    flush_ack      = 1'b0;
    redirect_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    exc_valid = 0; exc_code = '0; exc_pc = '0; exc_tval = '0; mret_valid = 0;
    commit_ready = 0; commit_pc = '0; csr_mip = '0; csr_mie = '0; csr_mstatus_mie = 0;
    csr_mtvec = '0; csr_mepc = '0; flush_ack = 0; redirect_ready = 0;
    rst = 1'b0;
    #1;
    do_reset();

    // Illegal instruction, immediate ack and ready
    issue_exc(6'd2, 64'h8000_0010, 64'h1234, 64'h8000_1001, 64'h8000_1000);
    ack_phase(0, 1'b0);
    redir_phase(0);

    // Interrupt priority: MEI over MSI/MTI, then MSI over MTI, then mode 11 non-vectored
    issue_irq(64'h888, 64'h8000_0040, 64'h8000_1001, 6'd11, EXP_MEI);
    ack_phase(0, 1'b0);
    redir_phase(0);
    issue_irq(64'h088, 64'h8000_0044, 64'h8000_1001, 6'd3, EXP_MSI);
    ack_phase(1, 1'b0);
    redir_phase(1);
    issue_irq(64'h080, 64'h8000_0048, 64'h8000_2003, 6'd7, 64'h8000_2000);
    ack_phase(0, 1'b0);
    redir_phase(0);

    // Masking: global disable, then not at an instruction boundary; stray ack in IDLE
    csr_mip = 64'h80; csr_mie = 64'h80; csr_mstatus_mie = 1'b0; commit_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mask_mie_busy", 64'(busy), 64'd0);
      check("mask_mie_flush", 64'(flush_req), 64'd0);
    end
    csr_mstatus_mie = 1'b1; commit_ready = 1'b0; flush_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mask_boundary_busy", 64'(busy), 64'd0);
      check("mask_boundary_flush", 64'(flush_req), 64'd0);
    end
    csr_mip = '0; csr_mie = '0; csr_mstatus_mie = 1'b0; flush_ack = 1'b0;

    // mret returns to mepc
    cq.push_back({1'b1, 1'b0, 6'd0, 64'd0, 64'd0});
    rq.push_back(64'h8000_0200);
    csr_mepc = 64'h8000_0200;
    mret_valid = 1'b1;
    tick();
    mret_valid = 1'b0;
    launch_checks();
    ack_phase(0, 1'b0);
    redir_phase(0);

    // mret and exception together: exception wins
    mret_valid = 1'b1;
    issue_exc(6'd3, 64'h8000_0300, 64'h0, 64'h8000_1001, 64'h8000_1000);
    mret_valid = 1'b0;
    ack_phase(0, 1'b0);
    redir_phase(0);

    // Backpressure with an exception pulsed while busy
    issue_exc(6'd5, 64'h8000_0400, 64'hDEAD, 64'h8000_3000, 64'h8000_3000);
    ack_phase(5, 1'b1);
    redir_phase(4);

    // Reset mid-DRAIN
    issue_exc(6'd4, 64'h8000_0500, 64'h1, 64'h8000_1000, 64'h8000_1000);
    tick();
    do_reset();

    // Reset mid-REDIRECT
    issue_exc(6'd4, 64'h8000_0600, 64'h2, 64'h8000_1000, 64'h8000_1000);
    ack_phase(0, 1'b0);
    tick();
    do_reset();

    // Normal completion after reset
    issue_exc(6'd1, 64'h8000_0700, 64'h77, 64'h8000_4001, 64'h8000_4000);
    ack_phase(2, 1'b0);
    redir_phase(2);

    tick();
    check("commit_queue_empty", 64'(cq.size()), 64'd0);
    check("redirect_queue_empty", 64'(rq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Machine-mode trap/return sequencer between the commit stage, the CSR file and the fetch unit. Arbitrates exceptions, `mret` and pending interrupts (priority exception > `mret` > interrupt), and drains the pipeline. It then issues one single-cycle trap/return commit to the CSR file and hands fetch a redirect PC computed from `mtvec`/`mepc`. All pipeline-visible outputs are Moore outputs of a 4-state FSM plus latched event registers.

## Interface
- XLEN, 64, datapath width (PCs, CSR values)
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- exc_valid  in  1  commit-stage exception present this cycle
- exc_code  in  6  exception cause code
- exc_pc  in  XLEN  PC of faulting instruction
- exc_tval  in  XLEN  trap value for faulting instruction
- mret_valid  in  1  `mret` at commit this cycle
- commit_ready  in  1  pipeline at instruction boundary (interrupts only taken when 1)
- commit_pc  in  XLEN  PC of next instruction to commit (interrupt epc)
- csr_mip, csr_mie  in  XLEN  pending / enable bits
- csr_mstatus_mie  in  1  global M-mode interrupt enable
- csr_mtvec, csr_mepc  in  XLEN  current CSR values
- flush_req  out  1  request pipeline drain
- flush_ack  in  1  drain complete
- trap_commit_valid  out  1  one-cycle commit strobe to CSR file
- trap_commit_mret  out  1  commit is a return (else trap entry)
- trap_commit_intr  out  1  trap is an interrupt (mcause MSB)
- trap_commit_code  out  6  cause code
- trap_commit_epc, trap_commit_tval  out  XLEN  values for mepc / mtval
- redirect_valid  out  1  fetch redirect pending
- redirect_pc  out  XLEN  redirect target
- redirect_ready  in  1  fetch accepts redirect
- busy  out  1  FSM not IDLE; pipeline must freeze commit

## Operation
- States: IDLE, DRAIN, COMMIT, REDIRECT.
- IDLE: event selection, highest first:
  - exc_valid=1: latch code, pc, tval; intr=0; mret=0.
  - mret_valid=1: latch mret=1; target = csr_mepc sampled now.
  - Interrupt: taken iff csr_mstatus_mie=1, commit_ready=1 and (csr_mip & csr_mie) has bit 11, 3 or 7 set. Priority MEI(11) > MSI(3) > MTI(7). Latch code, epc=commit_pc, tval=0, intr=1. Other mip bits are ignored.
- Any selected event moves IDLE->DRAIN and computes the trap target from csr_mtvec at capture:
  - mtvec[1:0]=01 and intr=1: (mtvec & ~3) + 4*code, modulo 2^XLEN.
  - Otherwise (modes 00/10/11, or exception): mtvec & ~3.
- DRAIN: flush_req=1; on flush_ack=1 -> COMMIT.
- COMMIT: trap_commit_valid=1 with latched fields for exactly one cycle -> REDIRECT.
- REDIRECT: redirect_valid=1, redirect_pc stable, until redirect_ready=1 -> IDLE.
- Any state other than IDLE: exc_valid, mret_valid and interrupts are ignored (busy=1 guarantees no loss).
- Simultaneous exc_valid and mret_valid: exception wins and the mret is dropped; the faulting mret reissues after handler return.

## Timing
- Reset, including mid-operation: state IDLE. Outputs flush_req, trap_commit_*, redirect_valid, busy and all data outputs are 0. Latches are cleared.
- Event sampled at edge N:
  - busy=1 and flush_req=1 from cycle N+1.
  - With flush_ack=1 at N+1: trap_commit_valid at N+2, redirect_valid from N+3.
  - Minimum 3 busy cycles.
- flush_ack is only sampled in DRAIN; ack asserted in IDLE has no effect.
- redirect_ready=0 holds REDIRECT indefinitely with all redirect outputs constant.
- The next event may be accepted at the first cycle after the REDIRECT handshake.
- trap_commit_* data outputs are valid only while trap_commit_valid=1; otherwise 0.

## Configuration
- TRAP_SEQUENCER_VECTORED_EN:
  - Defined: mtvec mode 01 vectors interrupts as described in Operation.
  - Undefined: mtvec[1:0] is ignored; every target is mtvec & ~3.
- Nothing else changes.

## Test plan
- Exception, illegal instruction: exc_code=2, exc_pc=0x8000_0010, tval=0x1234, mtvec=0x8000_1001, flush_ack immediate, redirect_ready=1. Expect trap_commit_valid one cycle (intr=0, code=2, epc=0x8000_0010, tval=0x1234) and redirect_pc=0x8000_1000.
- Interrupt priority: mip=mie=0x888, mstatus_mie=1, commit_ready=1, mtvec=0x8000_1001. Expect code=11, intr=1, epc=commit_pc. redirect_pc=0x8000_102C with VECTORED_EN, 0x8000_1000 without.
- Masking: mip=0x80, mie=0x80, mstatus_mie=0 (then commit_ready=0 with mstatus_mie=1). Expect busy stays 0 and no flush_req.
- mret with csr_mepc=0x8000_0200: expect trap_commit_mret=1 and redirect_pc=0x8000_0200. In the same cycle exc_valid=1 raises an exception instead (mret=0).
- Backpressure: flush_ack delayed 5 cycles, redirect_ready delayed 4 cycles, exc_valid pulsed while busy. Expect flush_req and redirect_valid held stable, a single commit, and the extra exception ignored.
- Reset mid-DRAIN and mid-REDIRECT: all outputs 0 immediately. A new event after reset completes normally.
